hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning number of ID-stage source register ports checked.
REQ-002 SHALL have parameter WB_LAT, default 3, meaning cycles from issue until the result is readable from the register file.
REQ-003 SHALL have parameter FWD_MAX, default 0, meaning the largest remaining-latency value still served by forwarding (0 = no forwarding).
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall statistics counter width.
REQ-005 clk_i  in  1  single clock, all state on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 id_valid_i  in  1  ID stage holds a valid instruction.
REQ-008 id_src_reg_i  in  NUM_SRC x REG_ADDR_WIDTH  source register addresses.
REQ-009 id_src_used_i  in  NUM_SRC  per-source "operand actually read" qualifier.
REQ-010 id_wb_en_i  in  1  instruction writes a register.
REQ-011 id_wb_reg_i  in  REG_ADDR_WIDTH  destination register.
REQ-012 flush_i  in  1  squash instruction issued in the previous cycle (now in EX) and the current ID instruction.
REQ-013 stat_clr_i  in  1  clear stall statistics.
REQ-014 pipeline_ready_o  out  1  ID may issue this cycle.
REQ-015 fwd_sel_o  out  NUM_SRC x clog2(WB_LAT+1)  per source: 0 = register file, k>0 = forward from producer with k cycles remaining.
REQ-016 stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 SHALL hold one busy counter per register, width clog2(WB_LAT+1); register 0 SHALL never be busy.
REQ-018 Issue SHALL occur when id_valid_i && pipeline_ready_o && !flush_i.
REQ-019 On issue with id_wb_en_i and id_wb_reg_i != 0, counter[id_wb_reg_i] SHALL load WB_LAT at the next edge, overriding any in-flight value (WAW reload).
REQ-020 Every other nonzero counter SHALL decrement by 1 each cycle, regardless of stall; counters SHALL never wrap below 0.
REQ-021 Source i SHALL be hazardous when id_src_used_i[i], id_src_reg_i[i] != 0 and counter[src] > FWD_MAX.
REQ-022 pipeline_ready_o SHALL be 0 when id_valid_i and any source is hazardous, else 1; combinational from current counters, zero added latency.
REQ-023 Sources SHALL be checked against pre-update counters, so an instruction reading its own destination sees only older producers.
REQ-024 fwd_sel_o[i] SHALL equal counter[src] when source i is used, nonzero and counter <= FWD_MAX, else 0.
REQ-025 On flush_i, every counter equal to WB_LAT-1 after decrement (i.e. value WB_LAT now) SHALL clear to 0, and no issue SHALL occur that cycle.
REQ-026 stall_cnt_o SHALL increment on each cycle with id_valid_i && !pipeline_ready_o && !flush_i, saturate at all-ones, and clear on stat_clr_i (clear wins over increment).

Reset
REQ-027 On rst_i all busy counters SHALL be 0, stall_cnt_o SHALL be 0, hence pipeline_ready_o = 1 and fwd_sel_o = 0 the cycle after reset.
REQ-028 Reset mid-operation SHALL discard all in-flight producers; no issue or count SHALL occur in a reset cycle.

Structure
REQ-029 REG_ADDR_WIDTH and the register count SHALL come from package risc16; a fwd_sel typedef SHALL be added there.
REQ-030 The saturating statistics counter SHALL be a sub-module named sat_counter; the scoreboard array stays in hazard_scoreboard.

Verification
REQ-031 WB_LAT=3, FWD_MAX=0: issue wb r3 at cycle 0, ID reads r3 from cycle 1 -> ready=0 cycles 1-3, ready=1 cycle 4, fwd_sel=0, stall_cnt=3.
REQ-032 WB_LAT=3, FWD_MAX=2: same stimulus -> ready=0 cycle 1 only, ready=1 cycle 2 with fwd_sel=2, cycle 3 fwd_sel=1.
REQ-033 Source r0, producer wb r0 -> never stalls, fwd_sel=0; source with id_src_used_i=0 on busy register -> no stall.
REQ-034 Issue wb r5 at cycle 0, flush_i at cycle 1 -> r5 not busy at cycle 2, ready=1 for reader of r5, stall_cnt unchanged.
REQ-035 WAW: wb r2 at cycle 0, wb r2 at cycle 2 -> reader of r2 (FWD_MAX=0) stalls until cycle 5.
REQ-036 CNT_W=4: force 20 stall cycles -> stall_cnt_o holds 15; stat_clr_i during stall -> 0 next cycle; rst_i mid-stall -> ready=1 next cycle.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared register-file geometry for the risc16 core and the forwarding-select type
// used by the hazard scoreboard.
package risc16;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;
    localparam int DEF_WB_LAT     = 3;

    // Width of a busy counter / forward select able to hold 0..wb_lat.
    function automatic int fwd_sel_width(input int wb_lat);
        return (wb_lat < 1) ? 1 : $clog2(wb_lat + 1);
    endfunction

    localparam int FWD_SEL_W = fwd_sel_width(DEF_WB_LAT);
    typedef logic [FWD_SEL_W-1:0] fwd_sel_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: one remaining-latency counter per register gates ID issue
// and picks a forwarding source when the producer is close enough to completion.
module hazard_scoreboard
    import risc16::*;
#(
    parameter int NUM_SRC = 2,
    parameter int WB_LAT  = 3,
    parameter int FWD_MAX = 0,
    parameter int CNT_W   = 16
) (
    input  logic                                                clk_i,
    input  logic                                                rst_i,
    input  logic                                                id_valid_i,
    input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]              id_src_reg_i,
    input  logic [NUM_SRC-1:0]                                  id_src_used_i,
    input  logic                                                id_wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0]                           id_wb_reg_i,
    input  logic                                                flush_i,
    input  logic                                                stat_clr_i,
    output logic                                                pipeline_ready_o,
    output logic [NUM_SRC-1:0][fwd_sel_width(WB_LAT)-1:0]       fwd_sel_o,
    output logic [CNT_W-1:0]                                    stall_cnt_o
);
    localparam int CW = fwd_sel_width(WB_LAT);

    logic [CW-1:0]      busy [NUM_REGS];
    logic [NUM_SRC-1:0] hazard;
    logic               issue;
    logic               stall;

    // Sources look at the counters before this cycle's update, so an instruction
    // that reads and writes the same register only waits on older producers.
    always_comb begin
        hazard    = '0;
        fwd_sel_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used_i[i] && (id_src_reg_i[i] != '0)) begin
                if (int'(busy[id_src_reg_i[i]]) > FWD_MAX)
                    hazard[i] = 1'b1;
                else
                    fwd_sel_o[i] = busy[id_src_reg_i[i]];
            end
        end
    end

    assign pipeline_ready_o = !(id_valid_i && (|hazard));
    assign issue            = id_valid_i && pipeline_ready_o && !flush_i;
    assign stall            = id_valid_i && !pipeline_ready_o && !flush_i;

    // A flush kills the instruction issued last cycle: its counter still reads WB_LAT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                busy[r] <= '0;
        end else begin
            busy[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue && id_wb_en_i && (id_wb_reg_i == REG_ADDR_WIDTH'(r)))
                    busy[r] <= CW'(WB_LAT);
                else if (flush_i && (busy[r] == CW'(WB_LAT)))
                    busy[r] <= '0;
                else if (busy[r] != '0)
                    busy[r] <= busy[r] - CW'(1);
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (stat_clr_i),
        .inc   (stall),
        .count (stall_cnt_o)
    );
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three parameterisations share one stimulus stream and
// are checked each cycle against a remaining-latency model plus directed vectors.
module tb_hazard_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, valid, wb_en, flush, clr;
    logic [1:0][3:0] src;
    logic [1:0]      used;
    logic [3:0]      wb_reg;

    logic            rdy0, rdy1, rdy2;
    logic [1:0][1:0] fwd0, fwd1, fwd2;
    logic [15:0]     sc0, sc1;
    logic [3:0]      sc2;

    hazard_scoreboard #(.NUM_SRC(2), .WB_LAT(3), .FWD_MAX(0), .CNT_W(16)) d0 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src_reg_i(src), .id_src_used_i(used),
        .id_wb_en_i(wb_en), .id_wb_reg_i(wb_reg), .flush_i(flush), .stat_clr_i(clr),
        .pipeline_ready_o(rdy0), .fwd_sel_o(fwd0), .stall_cnt_o(sc0));
    hazard_scoreboard #(.NUM_SRC(2), .WB_LAT(3), .FWD_MAX(2), .CNT_W(16)) d1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src_reg_i(src), .id_src_used_i(used),
        .id_wb_en_i(wb_en), .id_wb_reg_i(wb_reg), .flush_i(flush), .stat_clr_i(clr),
        .pipeline_ready_o(rdy1), .fwd_sel_o(fwd1), .stall_cnt_o(sc1));
    hazard_scoreboard #(.NUM_SRC(2), .WB_LAT(3), .FWD_MAX(0), .CNT_W(4)) d2 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(valid), .id_src_reg_i(src), .id_src_used_i(used),
        .id_wb_en_i(wb_en), .id_wb_reg_i(wb_reg), .flush_i(flush), .stat_clr_i(clr),
        .pipeline_ready_o(rdy2), .fwd_sel_o(fwd2), .stall_cnt_o(sc2));

    int n_cmp = 0, n_fail = 0;

    // Reference: each register remembers how many cycles until its value is in the file.
    int lat  [3] = '{3, 3, 3};
    int fmax [3] = '{0, 2, 0};
    int smax [3] = '{65535, 65535, 15};
    int remain [3][16];
    int stalls [3];
    bit mvalid = 0;

    typedef struct {
        bit valid; int s0; int s1; bit [1:0] used; bit wb_en; int wb_reg; bit flush; bit clr;
        int rdy0; int rdy1; int fwd1; int sc0;
    } vec_t;
    vec_t tbl [$];

    function automatic logic [31:0] get_rdy(int k);
        case (k) 0: return 32'(rdy0); 1: return 32'(rdy1); default: return 32'(rdy2); endcase
    endfunction
    function automatic logic [31:0] get_fwd(int k, int i);
        case (k) 0: return 32'(fwd0[i]); 1: return 32'(fwd1[i]); default: return 32'(fwd2[i]); endcase
    endfunction
    function automatic logic [31:0] get_sc(int k);
        case (k) 0: return 32'(sc0); 1: return 32'(sc1); default: return 32'(sc2); endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare all DUTs with the model mid-cycle, then advance the model to the next edge.
    task automatic check_edge();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            int  efwd [2];
            bit  blocked = 0;
            bit  ready, issue;
            for (int i = 0; i < 2; i++) begin
                efwd[i] = 0;
                if (used[i] && src[i] != 0) begin
                    if (remain[k][src[i]] > fmax[k]) blocked = 1;
                    else efwd[i] = remain[k][src[i]];
                end
            end
            ready = !(valid && blocked);
            if (mvalid) begin
                chk($sformatf("model_ready[d%0d]", k), get_rdy(k), int'(ready));
                for (int i = 0; i < 2; i++)
                    chk($sformatf("model_fwd[d%0d][%0d]", k, i), get_fwd(k, i), efwd[i]);
                chk($sformatf("model_stall[d%0d]", k), get_sc(k), stalls[k]);
            end
            if (rst) begin
                for (int r = 0; r < 16; r++) remain[k][r] = 0;
                stalls[k] = 0;
            end else begin
                issue = valid && ready && !flush;
                for (int r = 0; r < 16; r++) begin
                    if (flush && remain[k][r] == lat[k]) remain[k][r] = 0;
                    else if (remain[k][r] > 0) remain[k][r] = remain[k][r] - 1;
                end
                if (issue && wb_en && wb_reg != 0) remain[k][wb_reg] = lat[k];
                if (clr) stalls[k] = 0;
                else if (valid && !ready && !flush && stalls[k] < smax[k]) stalls[k]++;
            end
        end
        if (rst) mvalid = 1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] u,
                         input bit we, input int wr, input bit fl, input bit cl);
        valid = v; src[0] = 4'(s0); src[1] = 4'(s1); used = u;
        wb_en = we; wb_reg = 4'(wr); flush = fl; clr = cl;
    endtask

    task automatic add(input bit v, input int s0, input int s1, input bit [1:0] u, input bit we,
                       input int wr, input bit fl, input bit cl,
                       input int r0, input int r1, input int f1, input int c0);
        vec_t t;
        t.valid = v; t.s0 = s0; t.s1 = s1; t.used = u; t.wb_en = we; t.wb_reg = wr;
        t.flush = fl; t.clr = cl; t.rdy0 = r0; t.rdy1 = r1; t.fwd1 = f1; t.sc0 = c0;
        tbl.push_back(t);
    endtask

    initial begin
        //  v  s0 s1 used  we wr fl cl | rdy0 rdy1 fwd1 sc0
        add(1, 0, 0, 2'b00, 1, 3, 0, 0,   1, 1, 0, 0);   // producer r3
        add(1, 3, 0, 2'b01, 0, 0, 0, 0,   0, 0, 0, 0);
        add(1, 3, 0, 2'b01, 0, 0, 0, 0,   0, 1, 2, 1);
        add(1, 3, 0, 2'b01, 0, 0, 0, 0,   0, 1, 1, 2);
        add(1, 3, 0, 2'b01, 0, 0, 0, 0,   1, 1, 0, 3);
        add(0, 0, 0, 2'b00, 0, 0, 0, 0,   1, 1, 0, 3);
        add(1, 0, 0, 2'b00, 1, 0, 0, 0,   1, 1, 0, 3);   // write r0 is ignored
        add(1, 0, 0, 2'b01, 1, 4, 0, 0,   1, 1, 0, 3);   // read r0, produce r4
        add(1, 4, 4, 2'b00, 0, 0, 0, 0,   1, 1, 0, 3);   // busy r4 but not read
        add(1, 4, 4, 2'b00, 0, 0, 0, 0,   1, 1, 0, 3);
        add(1, 0, 0, 2'b00, 1, 5, 0, 0,   1, 1, 0, 3);   // producer r5
        add(1, 5, 0, 2'b01, 0, 0, 1, 0,   0, 0, 0, 3);   // flush squashes it
        add(1, 5, 0, 2'b01, 0, 0, 0, 0,   1, 1, 0, 3);
        add(1, 0, 0, 2'b00, 1, 2, 0, 0,   1, 1, 0, 3);   // WAW on r2
        add(1, 0, 0, 2'b00, 0, 0, 0, 0,   1, 1, 0, 3);
        add(1, 0, 0, 2'b00, 1, 2, 0, 0,   1, 1, 0, 3);
        add(1, 2, 0, 2'b01, 0, 0, 0, 0,   0, 0, 0, 3);
        add(1, 2, 0, 2'b01, 0, 0, 0, 0,   0, 1, 2, 4);
        add(1, 2, 0, 2'b01, 0, 0, 0, 0,   0, 1, 1, 5);
        add(1, 2, 0, 2'b01, 0, 0, 0, 0,   1, 1, 0, 6);
        add(0, 0, 0, 2'b00, 0, 0, 0, 1,   1, 1, 0, 6);   // clear stats
        add(0, 0, 0, 2'b00, 0, 0, 0, 0,   1, 1, 0, 0);

        rst = 1; drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
        advance();
        check_edge(); advance();
        rst = 0;

        foreach (tbl[n]) begin
            drive(tbl[n].valid, tbl[n].s0, tbl[n].s1, tbl[n].used, tbl[n].wb_en,
                  tbl[n].wb_reg, tbl[n].flush, tbl[n].clr);
            check_edge();
            chk($sformatf("vec%0d_ready_f0", n), 32'(rdy0), tbl[n].rdy0);
            chk($sformatf("vec%0d_ready_f2", n), 32'(rdy1), tbl[n].rdy1);
            chk($sformatf("vec%0d_fwd_f2", n), 32'(fwd1[0]), tbl[n].fwd1);
            chk($sformatf("vec%0d_stall_cnt", n), 32'(sc0), tbl[n].sc0);
            advance();
        end

        // Back-to-back read-modify-write of r7: 3 stalls per issue, 20 stalls in 27 cycles.
        drive(0, 0, 0, 2'b00, 0, 0, 0, 1); check_edge(); advance();
        drive(1, 7, 0, 2'b01, 1, 7, 0, 0);
        for (int c = 0; c < 27; c++) begin check_edge(); advance(); end
        clr = 1;
        check_edge();
        chk("sat_wide_cnt", 32'(sc0), 20);
        chk("sat_narrow_cnt", 32'(sc2), 15);
        chk("clr_cycle_stalled", 32'(rdy0), 0);
        advance();
        clr = 0;
        check_edge();
        chk("clr_wide", 32'(sc0), 0);
        chk("clr_narrow", 32'(sc2), 0);
        chk("post_clr_ready", 32'(rdy0), 1);
        advance();
        rst = 1;
        check_edge();
        chk("pre_rst_stalled", 32'(rdy0), 0);
        advance();
        rst = 0;
        check_edge();
        chk("post_rst_ready_f0", 32'(rdy0), 1);
        chk("post_rst_ready_f2", 32'(rdy1), 1);
        chk("post_rst_stall_cnt", 32'(sc2), 0);
        advance();

        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
                  2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(7),
                  $urandom_range(7) == 0, $urandom_range(31) == 0);
            check_edge();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
